cardinal_nic: RTL and testbench
===============================

# cardinal_nic

Network interface controller sitting between the cardinal processor's NIC port and one router port of the CMP ring/mesh. It is the responder for the processor's `nicEn`/`nicWrEn`/`nic_addr`/`d_out` accesses and returns `nic_data`. Toward the network it holds one 64-bit input channel buffer and one 64-bit output channel buffer, each guarded by a full flag, with send/ready handshakes and virtual-channel polarity gating on injection.

## Interface
- `DATA_WIDTH`, default 64: packet and processor data width; all buses are big-endian `[0:DATA_WIDTH-1]`.
- `ADDR_WIDTH`, default 3: width of the NIC register address.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `nic_addr`  in  [0:2]: register select from the processor.
- `nicEn`  in  1: access enable from the processor.
- `nicWrEn`  in  1: write when 1, read when 0; meaningful only with `nicEn`.
- `d_out`  in  [0:63]: write data from the processor.
- `nic_data`  out  [0:63]: read data to the processor.
- `net_si`  in  1: router is sending a packet to the NIC.
- `net_ri`  out  1: NIC can accept a packet.
- `net_di`  in  [0:63]: packet from the router.
- `net_so`  out  1: NIC is sending a packet to the router.
- `net_ro`  in  1: router can accept a packet.
- `net_do`  out  [0:63]: packet to the router.
- `net_polarity`  in  1: router's current virtual-channel polarity.

## Operation
- **Register map**
  - 0: input channel buffer (read).
  - 1: input status (read).
  - 2: output channel buffer (write).
  - 3: output status (read).
  - 4–7: reserved. Reads return 0; writes are ignored.
- **Status reads** return the flag in bit 63; bits 0–62 are 0.
- **Reads** are combinational. `nic_data` equals the selected register when `nicEn & ~nicWrEn`, else 0.
- **Reading address 0** clears `in_full` at the next edge. This happens only when `in_full=1`. Reading an empty buffer returns stale data and changes no state.
- **Input channel**
  - `net_ri = ~in_full & ~reset`.
  - When `net_si & net_ri` at an edge: `in_buf <= net_di`, `in_full <= 1`.
  - `net_si` while `net_ri=0` is a protocol violation and is ignored.
- **Output channel, processor write**
  - Write to address 2 with `out_full=0`: `out_buf <= d_out`, `out_full <= 1`.
  - Write to address 2 with `out_full=1`: dropped. The buffer is not overwritten.
- **Output channel, injection**
  - `net_so = out_full & net_ro & (out_buf[0] == net_polarity)`. Bit 0 is the packet's VC bit.
  - `net_do = out_buf` at all times.
  - When `net_so=1` at an edge, `out_full <= 0`.
- **Writes to addresses 0, 1, 3** are ignored.
- **Per-channel full-flag state machine**
  - EMPTY → FULL on load: network capture for input, processor write for output.
  - FULL → EMPTY on drain: processor read for input, `net_so` for output.
  - No other transitions.

## Timing
- **Reset:** `in_buf`, `out_buf`, `in_full`, `out_full` all 0. Outputs during and after reset: `net_so=0`, `net_do=0`, `net_ri=0` while reset is high, `net_ri=1` the cycle after release, `nic_data=0` unless a read is presented.
- **Reset mid-operation** discards both buffers immediately, regardless of the clock.
- **Network → processor latency:** a packet captured at edge N makes status read 1 from cycle N+1. The read of address 0 in cycle M returns the data, and `net_ri` rises in cycle M+1.
- **Processor → network latency:** a write at edge N allows `net_so` in cycle N+1 at the earliest, subject to `net_ro` and polarity.
- **Injection holds** while polarity mismatches or `net_ro=0`. `net_do` stays stable during the hold.
- **Simultaneous write to address 2 and `net_so`:** the write is dropped, because `out_full` was 1 at the edge. Software re-polls address 3.
- **Simultaneous `net_si` and address-0 read:** cannot occur, since `net_ri=0` whenever `in_full=1`. Back-to-back throughput is one packet per 2 cycles per channel.

## Structure
- **Package `cardinal_nic_pkg`:**
  - address constants `NIC_IN_BUF=0`, `NIC_IN_STS=1`, `NIC_OUT_BUF=2`, `NIC_OUT_STS=3`.
  - `VC_BIT=0`.
  - the `DATA_WIDTH` default.
- **Sub-module `nic_channel_buffer`:**
  - a 64-bit register plus full flag, with `load`/`drain` inputs and async reset.
  - instantiated twice, once for input and once for output.
  - a load while full is blocked inside the sub-module.
- **Top level** contains only address decode, the read mux and the handshake gating.

## Test plan
1. Reset asserted mid-cycle with both buffers full → all flags 0 immediately, `net_so=0`, `net_ri=1` one cycle after release, status reads return 0.
2. `net_si=1`, `net_di=64'hA5A5_0000_0000_1234` → next cycle status(1) reads 64'h1, `net_ri=0`; read address 0 returns `A5A5_0000_0000_1234`; `net_ri=1` the following cycle.
3. Write address 2 with `64'h8000_0000_0000_00FF`, `net_ro=1`, `net_polarity=0` for 3 cycles then 1 → `net_so` is low during the 3 cycles, pulses 1 for exactly one cycle once polarity is 1, then status(3) reads 0.
4. Write address 2 with `64'h1` (`out_full=0`), then write `64'h2` while `net_ro=0` → `net_do` stays 64'h1, second write dropped, status(3)=1.
5. Second `net_si` offered while `in_full=1` → `net_ri=0`, `in_buf` unchanged; read/write to addresses 4–7 → `nic_data=0`, no state change.

Source files
------------

// File: rtl/cardinal_nic_pkg.sv
// Shared constants and types for the cardinal NIC: register map, VC bit position,
// default widths and the per-channel full-flag state encoding.
package cardinal_nic_pkg;

    localparam int NIC_DATA_WIDTH = 64;
    localparam int NIC_ADDR_WIDTH = 3;

    localparam int NIC_IN_BUF  = 0;
    localparam int NIC_IN_STS  = 1;
    localparam int NIC_OUT_BUF = 2;
    localparam int NIC_OUT_STS = 3;

    // Bit 0 (MSB of the big-endian packet) carries the virtual-channel select.
    localparam int VC_BIT = 0;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

endpackage

// File: rtl/nic_channel_buffer.sv
// One packet register guarded by an EMPTY/FULL state machine. A load is accepted
// only while EMPTY; a drain only takes effect while FULL. State is exported as-is.
module nic_channel_buffer
    import cardinal_nic_pkg::*;
#(
    parameter int DATA_WIDTH = NIC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  drain,
    input  logic [0:DATA_WIDTH-1] din,
    output logic [0:DATA_WIDTH-1] dout,
    output ch_state_t             state
);

    ch_state_t             state_q;
    ch_state_t             state_d;
    logic [0:DATA_WIDTH-1] data_q;
    logic                  load_ok;

    assign load_ok = load && (state_q == CH_EMPTY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            CH_EMPTY: if (load)  state_d = CH_FULL;
            CH_FULL:  if (drain) state_d = CH_EMPTY;
            default:             state_d = CH_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CH_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_ok) begin
                data_q <= din;
            end
        end
    end

    assign dout  = data_q;
    assign state = state_q;

endmodule

// File: rtl/cardinal_nic.sv
// NIC between the cardinal processor port and one router port: register decode,
// combinational read mux, and send/ready gating around two channel buffers.
module cardinal_nic
    import cardinal_nic_pkg::*;
#(
    parameter int DATA_WIDTH = NIC_DATA_WIDTH,
    parameter int ADDR_WIDTH = NIC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:ADDR_WIDTH-1] nic_addr,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic [0:DATA_WIDTH-1] d_out,
    output logic [0:DATA_WIDTH-1] nic_data,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    // Handshake: a transfer happens on a rising edge where the sender's send
    // (net_si / net_so) and the receiver's ready (net_ri / net_ro) are both 1;
    // send must never be raised toward a receiver whose ready is 0.

    logic                  rd_en;
    logic                  wr_en;
    logic                  sel_in_buf;
    logic                  sel_in_sts;
    logic                  sel_out_buf;
    logic                  sel_out_sts;
    logic                  in_full;
    logic                  out_full;
    logic                  in_load;
    logic                  in_drain;
    logic                  out_load;
    logic [0:DATA_WIDTH-1] in_buf;
    logic [0:DATA_WIDTH-1] out_buf;
    ch_state_t             in_state;
    ch_state_t             out_state;

    assign rd_en = nicEn & ~nicWrEn;
    assign wr_en = nicEn & nicWrEn;

    assign sel_in_buf  = (nic_addr == ADDR_WIDTH'(NIC_IN_BUF));
    assign sel_in_sts  = (nic_addr == ADDR_WIDTH'(NIC_IN_STS));
    assign sel_out_buf = (nic_addr == ADDR_WIDTH'(NIC_OUT_BUF));
    assign sel_out_sts = (nic_addr == ADDR_WIDTH'(NIC_OUT_STS));

    assign in_full  = (in_state == CH_FULL);
    assign out_full = (out_state == CH_FULL);

    // Ready drops combinationally with reset so nothing is offered while buffers clear.
    assign net_ri   = ~in_full & ~reset;
    assign in_load  = net_si & net_ri;
    assign in_drain = rd_en & sel_in_buf;

    assign out_load = wr_en & sel_out_buf;
    assign net_so   = out_full & net_ro & (out_buf[VC_BIT] == net_polarity);
    assign net_do   = out_buf;

    always_comb begin
        nic_data = '0;
        if (rd_en) begin
            if (sel_in_buf)       nic_data = in_buf;
            else if (sel_in_sts)  nic_data = DATA_WIDTH'(in_full);
            else if (sel_out_sts) nic_data = DATA_WIDTH'(out_full);
        end
    end

    nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_in_chan (
        .clk   (clk),
        .reset (reset),
        .load  (in_load),
        .drain (in_drain),
        .din   (net_di),
        .dout  (in_buf),
        .state (in_state)
    );

    nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_out_chan (
        .clk   (clk),
        .reset (reset),
        .load  (out_load),
        .drain (net_so),
        .din   (d_out),
        .dout  (out_buf),
        .state (out_state)
    );

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed bench for cardinal_nic: reset, input capture/drain, polarity-gated
// injection, dropped writes, protocol violations and reserved addresses.
module tb_cardinal_nic;

    logic        clk;
    logic        reset;
    logic [0:2]  nic_addr;
    logic        nicEn;
    logic        nicWrEn;
    logic [0:63] d_out;
    logic [0:63] nic_data;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    int errors = 0;
    int checks = 0;

    cardinal_nic dut (
        .clk          (clk),
        .reset        (reset),
        .nic_addr     (nic_addr),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .d_out        (d_out),
        .nic_data     (nic_data),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        nicEn    = 1'b0;
        nicWrEn  = 1'b0;
        nic_addr = 3'd0;
        d_out    = '0;
        net_si   = 1'b0;
        net_di   = '0;
    endtask

    task automatic proc_read(input logic [0:2] a);
        nicEn    = 1'b1;
        nicWrEn  = 1'b0;
        nic_addr = a;
        #1;
    endtask

    task automatic proc_write(input logic [0:2] a, input logic [0:63] d);
        nicEn    = 1'b1;
        nicWrEn  = 1'b1;
        nic_addr = a;
        d_out    = d;
        #1;
    endtask

    task automatic test_reset();
        // fill both channels, then assert reset mid-cycle
        net_ro = 1'b0;
        net_polarity = 1'b0;
        net_si = 1'b1;
        net_di = 64'h1111_2222_3333_4444;
        proc_write(3'd2, 64'h0000_0000_0000_0055);
        cycle();
        idle();
        net_ro = 1'b1;
        #1;
        if (net_so !== 1'b1) begin
            errors++; $display("FAIL rst_pre_so: got %b expected 1", net_so);
        end
        checks++;
        #2 reset = 1'b1;
        #1;
        if (net_so !== 1'b0) begin
            errors++; $display("FAIL rst_async_so: got %b expected 0", net_so);
        end
        checks++;
        if (net_do !== 64'h0) begin
            errors++; $display("FAIL rst_async_do: got %h expected 0", net_do);
        end
        checks++;
        if (net_ri !== 1'b0) begin
            errors++; $display("FAIL rst_ri_low: got %b expected 0", net_ri);
        end
        checks++;
        proc_read(3'd1);
        if (nic_data !== 64'h0) begin
            errors++; $display("FAIL rst_in_sts: got %h expected 0", nic_data);
        end
        checks++;
        proc_read(3'd3);
        if (nic_data !== 64'h0) begin
            errors++; $display("FAIL rst_out_sts: got %h expected 0", nic_data);
        end
        checks++;
        idle();
        cycle();
        #2 reset = 1'b0;
        cycle();
        if (net_ri !== 1'b1) begin
            errors++; $display("FAIL rst_ri_after: got %b expected 1", net_ri);
        end
        checks++;
        if (nic_data !== 64'h0) begin
            errors++; $display("FAIL rst_nic_data_idle: got %h expected 0", nic_data);
        end
        checks++;
        net_ro = 1'b0;
    endtask

    task automatic test_input_channel();
        net_si = 1'b1;
        net_di = 64'hA5A5_0000_0000_1234;
        cycle();
        idle();
        proc_read(3'd1);
        if (nic_data !== 64'h1) begin
            errors++; $display("FAIL in_sts_full: got %h expected 1", nic_data);
        end
        checks++;
        if (net_ri !== 1'b0) begin
            errors++; $display("FAIL in_ri_busy: got %b expected 0", net_ri);
        end
        checks++;
        proc_read(3'd0);
        if (nic_data !== 64'hA5A5_0000_0000_1234) begin
            errors++; $display("FAIL in_buf_read: got %h expected a5a5000000001234", nic_data);
        end
        checks++;
        cycle();
        idle();
        #1;
        if (net_ri !== 1'b1) begin
            errors++; $display("FAIL in_ri_after_read: got %b expected 1", net_ri);
        end
        checks++;
        // stale read of an empty buffer changes nothing
        proc_read(3'd0);
        if (nic_data !== 64'hA5A5_0000_0000_1234) begin
            errors++; $display("FAIL in_stale_read: got %h expected a5a5000000001234", nic_data);
        end
        checks++;
        cycle();
        proc_read(3'd1);
        if (nic_data !== 64'h0) begin
            errors++; $display("FAIL in_sts_after_stale: got %h expected 0", nic_data);
        end
        checks++;
        idle();
    endtask

    task automatic test_injection();
        net_ro = 1'b1;
        net_polarity = 1'b0;
        proc_write(3'd2, 64'h8000_0000_0000_00FF);
        if (net_so !== 1'b0) begin
            errors++; $display("FAIL inj_so_before_edge: got %b expected 0", net_so);
        end
        checks++;
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            if (net_so !== 1'b0 || net_do !== 64'h8000_0000_0000_00FF) begin
                errors++;
                $display("FAIL inj_hold_%0d: got so=%b do=%h expected so=0 do=80000000000000ff", i, net_so, net_do);
            end
            checks++;
            cycle();
        end
        net_polarity = 1'b1;
        #1;
        if (net_so !== 1'b1) begin
            errors++; $display("FAIL inj_so_pulse: got %b expected 1", net_so);
        end
        checks++;
        cycle();
        if (net_so !== 1'b0) begin
            errors++; $display("FAIL inj_so_one_cycle: got %b expected 0", net_so);
        end
        checks++;
        proc_read(3'd3);
        if (nic_data !== 64'h0) begin
            errors++; $display("FAIL inj_out_sts: got %h expected 0", nic_data);
        end
        checks++;
        idle();
        net_polarity = 1'b0;
    endtask

    task automatic test_write_drop();
        net_ro = 1'b0;
        proc_write(3'd2, 64'h1);
        cycle();
        proc_write(3'd2, 64'h2);
        cycle();
        idle();
        #1;
        if (net_do !== 64'h1) begin
            errors++; $display("FAIL drop_do: got %h expected 1", net_do);
        end
        checks++;
        proc_read(3'd3);
        if (nic_data !== 64'h1) begin
            errors++; $display("FAIL drop_out_sts: got %h expected 1", nic_data);
        end
        checks++;
        if (net_so !== 1'b0) begin
            errors++; $display("FAIL drop_so_ro_low: got %b expected 0", net_so);
        end
        checks++;
        idle();
        // VC bit of 64'h1 is 0, matching polarity 0
        net_ro = 1'b1;
        #1;
        if (net_so !== 1'b1) begin
            errors++; $display("FAIL drop_drain_so: got %b expected 1", net_so);
        end
        checks++;
        cycle();
        net_ro = 1'b0;
        proc_read(3'd3);
        if (nic_data !== 64'h0) begin
            errors++; $display("FAIL drop_drained_sts: got %h expected 0", nic_data);
        end
        checks++;
        idle();
    endtask

    task automatic test_back_to_back();
        // write lands in the same edge the previous packet leaves: dropped
        net_ro = 1'b0;
        net_polarity = 1'b0;
        proc_write(3'd2, 64'h3);
        cycle();
        net_ro = 1'b1;
        proc_write(3'd2, 64'h4);
        if (net_so !== 1'b1) begin
            errors++; $display("FAIL b2b_so: got %b expected 1", net_so);
        end
        checks++;
        cycle();
        net_ro = 1'b0;
        proc_read(3'd3);
        if (nic_data !== 64'h0 || net_do !== 64'h3) begin
            errors++; $display("FAIL b2b_write_dropped: got sts=%h do=%h expected sts=0 do=3", nic_data, net_do);
        end
        checks++;
        // input channel: two packets, one every 2 cycles
        idle();
        net_si = 1'b1;
        net_di = 64'hC0DE_0000_0000_0001;
        cycle();
        net_si = 1'b0;
        proc_read(3'd0);
        if (nic_data !== 64'hC0DE_0000_0000_0001) begin
            errors++; $display("FAIL b2b_pkt1: got %h expected c0de000000000001", nic_data);
        end
        checks++;
        cycle();
        idle();
        net_si = 1'b1;
        net_di = 64'hC0DE_0000_0000_0002;
        #1;
        if (net_ri !== 1'b1) begin
            errors++; $display("FAIL b2b_ri: got %b expected 1", net_ri);
        end
        checks++;
        cycle();
        net_si = 1'b0;
        proc_read(3'd0);
        if (nic_data !== 64'hC0DE_0000_0000_0002) begin
            errors++; $display("FAIL b2b_pkt2: got %h expected c0de000000000002", nic_data);
        end
        checks++;
        cycle();
        idle();
    endtask

    task automatic test_violation_reserved();
        net_si = 1'b1;
        net_di = 64'h0123_4567_89AB_CDEF;
        cycle();
        net_di = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        if (net_ri !== 1'b0) begin
            errors++; $display("FAIL viol_ri: got %b expected 0", net_ri);
        end
        checks++;
        cycle();
        net_si = 1'b0;
        proc_read(3'd0);
        if (nic_data !== 64'h0123_4567_89AB_CDEF) begin
            errors++; $display("FAIL viol_in_buf: got %h expected 0123456789abcdef", nic_data);
        end
        checks++;
        // writes to reserved and read-only addresses must leave state alone
        for (int a = 4; a < 8; a++) begin
            proc_read(3'(a));
            if (nic_data !== 64'h0) begin
                errors++; $display("FAIL rsvd_read_%0d: got %h expected 0", a, nic_data);
            end
            checks++;
            proc_write(3'(a), 64'hFFFF_FFFF_FFFF_FFFF);
            cycle();
        end
        proc_write(3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        proc_write(3'd1, 64'h0);
        cycle();
        proc_write(3'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        proc_read(3'd1);
        if (nic_data !== 64'h1) begin
            errors++; $display("FAIL rsvd_in_sts: got %h expected 1", nic_data);
        end
        checks++;
        proc_read(3'd3);
        if (nic_data !== 64'h0) begin
            errors++; $display("FAIL rsvd_out_sts: got %h expected 0", nic_data);
        end
        checks++;
        proc_read(3'd0);
        if (nic_data !== 64'h0123_4567_89AB_CDEF) begin
            errors++; $display("FAIL rsvd_in_buf: got %h expected 0123456789abcdef", nic_data);
        end
        checks++;
        if (net_do !== 64'h3) begin
            errors++; $display("FAIL rsvd_out_buf: got %h expected 3", net_do);
        end
        checks++;
        cycle();
        idle();
    endtask

    initial begin
        reset        = 1'b1;
        net_ro       = 1'b0;
        net_polarity = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        cycle();
        test_reset();
        test_input_channel();
        test_injection();
        test_write_drop();
        test_back_to_back();
        test_violation_reserved();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
